// File: rtl/bin_ram_pkg.sv
// Shared constants and types for the binary-mask RAM and its arbiter.
package bin_ram_pkg;
  localparam int BIN_ADDR_WIDTH   = 11;
  localparam int BIN_DATA_WIDTH   = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;
endpackage

// File: rtl/bin_ram.sv
// 2048x1 single-port mask RAM: normal write mode (output holds during writes),
// unregistered output path, one-cycle read latency.
module bin_ram
  import bin_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = BIN_ADDR_WIDTH,
  parameter int DATA_WIDTH = BIN_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= '0;
    else if (!wr_en) rd_data <= mem[addr];
  end
endmodule

// File: rtl/bin_ram_arbiter.sv
// Shares one bin_ram between the binarizer write stream and the mask reader:
// write priority with bounded read starvation, plus a full-memory clear sweep.
module bin_ram_arbiter
  import bin_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = BIN_ADDR_WIDTH,
  parameter int DATA_WIDTH   = BIN_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output arb_state_e            dbg_state
);
  // Handshakes: a transfer happens in a cycle where valid & ready are both high;
  // ready is a combinational grant that never registers the request.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e            state, next_state;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;
  logic [3:0]            starve_cnt, starve_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr, ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rd, rsp_hold;
  logic                  ram_we, rsp_valid_q, done_nxt, clear_done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_RUN;
      clr_addr     <= '0;
      starve_cnt   <= '0;
      ram_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hold     <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state        <= next_state;
      clr_addr     <= clr_addr_nxt;
      starve_cnt   <= starve_nxt;
      ram_addr_q   <= ram_addr;
      rsp_valid_q  <= rd_valid & rd_ready;
      clear_done_q <= done_nxt;
      if (rsp_valid_q) rsp_hold <= ram_rd;
    end
  end

  always_comb begin
    next_state   = state;
    clr_addr_nxt = clr_addr;
    starve_nxt   = '0;
    done_nxt     = 1'b0;
    wr_ready     = 1'b0;
    rd_ready     = 1'b0;
    ram_addr     = ram_addr_q;
    ram_wdata    = wr_data;
    ram_we       = 1'b0;
    case (state)
      ST_RUN: begin
        // Grants are suppressed while reset is held so nothing reaches the RAM.
        if (!rstn) begin
          next_state = ST_RUN;
        end else if (clear_req) begin
          next_state   = ST_CLEAR;
          clr_addr_nxt = '0;
        end else if (wr_valid && (!rd_valid || starve_cnt < LIMIT)) begin
          wr_ready = 1'b1;
          ram_addr = wr_addr;
          ram_we   = 1'b1;
          if (rd_valid) starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
        end else if (rd_valid) begin
          rd_ready = 1'b1;
          ram_addr = rd_addr;
        end
      end
      ST_CLEAR: begin
        ram_addr     = clr_addr;
        ram_wdata    = '0;
        ram_we       = 1'b1;
        clr_addr_nxt = clr_addr + 1'b1;
        if (&clr_addr) begin
          next_state = ST_RUN;
          done_nxt   = 1'b1;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  // Response data follows the RAM only in the response cycle, else holds.
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_valid_q ? ram_rd : rsp_hold;
  assign clear_busy = (state == ST_CLEAR);
  assign clear_done = clear_done_q;
  assign dbg_state  = state;

  bin_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .addr    (ram_addr),
    .wr_data (ram_wdata),
    .rd_data (ram_rd),
    .wr_en   (ram_we),
    .clk     (clk),
    .rst     (~rstn)
  );
endmodule
